// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA scan controller: default 640x480@60 timing,
// counter width, raster region encoding, RGB and sync bundle types.
// ----------------------------------------------------------------------------
package vga_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef enum logic [1:0] {
        RegActive,
        RegFp,
        RegSync,
        RegBp
    } region_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    // Raw timing bits that travel alongside the layer latency.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

    // Index of the last count of a span of n counts (n >= 1).
    function automatic logic [CNT_W-1:0] cnt_last(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/vga_region_cnt.sv
// ----------------------------------------------------------------------------
// vga_region_cnt
// One raster axis: a counter over ACTIVE+FP+SYNC+BP positions plus the region
// FSM (ACTIVE -> FP -> SYNC -> BP -> ACTIVE). Used for both the horizontal
// axis (stepped by the pixel enable) and the vertical axis (stepped by the
// horizontal wrap strobe). All four widths must be non-zero and their sum
// must not exceed 1024.
//
// Ports
//   i_clk     clock
//   i_rst     synchronous active-high reset, returns to count 0 / ACTIVE
//   i_step    advance by one position
//   o_cnt     current position
//   o_region  region of the current position
//   o_wrap    i_step while at the last position (next position is 0)
// ----------------------------------------------------------------------------
module vga_region_cnt
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned FP     = VGA_H_FP,
    parameter int unsigned SYNC   = VGA_H_SYNC,
    parameter int unsigned BP     = VGA_H_BP
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_step,
    output logic [CNT_W-1:0] o_cnt,
    output region_e          o_region,
    output logic             o_wrap
);

    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [CNT_W-1:0] L_ACT_END  = cnt_last(ACTIVE);
    localparam logic [CNT_W-1:0] L_FP_END   = cnt_last(ACTIVE + FP);
    localparam logic [CNT_W-1:0] L_SYNC_END = cnt_last(ACTIVE + FP + SYNC);
    localparam logic [CNT_W-1:0] L_LAST     = cnt_last(TOTAL);

    logic [CNT_W-1:0] r_cnt;
    region_e          r_region;
    logic             w_last;

    assign w_last   = (r_cnt == L_LAST);
    assign o_wrap   = i_step & w_last;
    assign o_cnt    = r_cnt;
    assign o_region = r_region;

    // Region changes on the step that leaves the last position of a region,
    // so the region register always describes the current count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_region <= RegActive;
        end else if (i_step) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            case (r_region)
                RegActive: if (r_cnt == L_ACT_END)  r_region <= RegFp;
                RegFp:     if (r_cnt == L_FP_END)   r_region <= RegSync;
                RegSync:   if (r_cnt == L_SYNC_END) r_region <= RegBp;
                RegBp:     if (w_last)              r_region <= RegActive;
                default:                            r_region <= RegActive;
            endcase
        end
    end

endmodule

// File: rtl/vga_scan_ctrl.sv
// ----------------------------------------------------------------------------
// vga_scan_ctrl
// Display scan controller. Generates raster coordinates for the pixel layers,
// delays the raw syncs / display enable by the layer latency, composites two
// layers by fixed priority (layer 1 over layer 2 over BG_RGB) and registers
// the VGA outputs. Everything advances only when i_en is high.
//
// Ports
//   i_clk, i_rst, i_en          clock, sync active-high reset, pixel enable
//   o_x_pos, o_y_pos            active-area coordinates (0 outside)
//   o_pos_valid                 coordinates inside the active area
//   o_frame_start               high while the raster sits at (0,0)
//   i_rq_flag1, i_r1/g1/b1      foreground layer request and colour
//   i_rq_flag2, i_r2/g2/b2      background layer request and colour
//   o_vga_r/g/b                 composited pixel
//   o_vga_hs, o_vga_vs          active-low syncs
//   o_vga_de                    display enable
// LAYER_LAT is the layer response latency in en cycles (0..4); VGA outputs
// lag o_x_pos/o_y_pos by LAYER_LAT+1 en cycles.
// ----------------------------------------------------------------------------
module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
    parameter int unsigned H_FP      = VGA_H_FP,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BP      = VGA_H_BP,
    parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
    parameter int unsigned V_FP      = VGA_V_FP,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BP      = VGA_V_BP,
    parameter int unsigned LAYER_LAT = 1,
    parameter logic [23:0] BG_RGB    = 24'h000000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_x_pos,
    output logic [CNT_W-1:0] o_y_pos,
    output logic             o_pos_valid,
    output logic             o_frame_start,
    input  logic             i_rq_flag1,
    input  logic [7:0]       i_r1,
    input  logic [7:0]       i_g1,
    input  logic [7:0]       i_b1,
    input  logic             i_rq_flag2,
    input  logic [7:0]       i_r2,
    input  logic [7:0]       i_g2,
    input  logic [7:0]       i_b2,
    output logic [7:0]       o_vga_r,
    output logic [7:0]       o_vga_g,
    output logic [7:0]       o_vga_b,
    output logic             o_vga_hs,
    output logic             o_vga_vs,
    output logic             o_vga_de
);

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    region_e          w_h_region;
    region_e          w_v_region;
    logic             w_h_wrap;
    logic             w_v_wrap;

    vga_region_cnt #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_cnt (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_step   (i_en),
        .o_cnt    (w_h_cnt),
        .o_region (w_h_region),
        .o_wrap   (w_h_wrap)
    );

    vga_region_cnt #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_cnt (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_step   (w_h_wrap),
        .o_cnt    (w_v_cnt),
        .o_region (w_v_region),
        .o_wrap   (w_v_wrap)
    );

    assign o_x_pos     = (w_h_region == RegActive) ? w_h_cnt : '0;
    assign o_y_pos     = (w_v_region == RegActive) ? w_v_cnt : '0;
    assign o_pos_valid = (w_h_region == RegActive) && (w_v_region == RegActive);

    // r_at_origin tracks "counters are at (0,0)": set by reset and by the
    // edge that wraps the whole frame. Masking with i_rst keeps the strobe
    // low while reset is held even though the counters already sit at 0.
    logic r_at_origin;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_at_origin <= 1'b1;
        end else if (i_en) begin
            r_at_origin <= w_v_wrap;
        end
    end

    assign o_frame_start = r_at_origin & ~i_rst;

    // ------------------------------------------------------------------
    // Sync / enable delay line matching the layer latency
    // ------------------------------------------------------------------
    sync_t w_sync_raw;
    sync_t w_sync_al;

    always_comb begin
        w_sync_raw    = SYNC_IDLE;
        w_sync_raw.hs = (w_h_region != RegSync);
        w_sync_raw.vs = (w_v_region != RegSync);
        w_sync_raw.de = o_pos_valid;
    end

    generate
        if (LAYER_LAT == 0) begin : g_no_dly
            assign w_sync_al = w_sync_raw;
        end else begin : g_dly
            sync_t r_dly [LAYER_LAT];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int unsigned i = 0; i < LAYER_LAT; i++) begin
                        r_dly[i] <= SYNC_IDLE;
                    end
                end else if (i_en) begin
                    r_dly[0] <= w_sync_raw;
                    for (int unsigned i = 1; i < LAYER_LAT; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end

            assign w_sync_al = r_dly[LAYER_LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Priority composite and output register
    // ------------------------------------------------------------------
    rgb24_t w_pix;
    rgb24_t r_rgb;
    logic   r_hs;
    logic   r_vs;
    logic   r_de;

    always_comb begin
        w_pix = '0;
        if (w_sync_al.de) begin
            if (i_rq_flag1) begin
                w_pix = {i_r1, i_g1, i_b1};
            end else if (i_rq_flag2) begin
                w_pix = {i_r2, i_g2, i_b2};
            end else begin
                w_pix = BG_RGB;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rgb <= '0;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
            r_de  <= 1'b0;
        end else if (i_en) begin
            r_rgb <= w_pix;
            r_hs  <= w_sync_al.hs;
            r_vs  <= w_sync_al.vs;
            r_de  <= w_sync_al.de;
        end
    end

    assign o_vga_r  = r_rgb.r;
    assign o_vga_g  = r_rgb.g;
    assign o_vga_b  = r_rgb.b;
    assign o_vga_hs = r_hs;
    assign o_vga_vs = r_vs;
    assign o_vga_de = r_de;

endmodule
